// File: rtl/tset_pkg.sv
// Shared definitions for the Tset entry derivation stage: FSM state encoding,
// default field widths and a generic bit-field extraction helper.
package tset_pkg;

    localparam int TSET_B_W   = 8;
    localparam int TSET_L_W   = 48;
    localparam int TSET_CNT_W = 16;
    localparam int TSET_M_W   = 128 - TSET_B_W - TSET_L_W;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LDK1,
        ST_WK1,
        ST_ENC1,
        ST_WD1,
        ST_LDK2,
        ST_WK2,
        ST_ENC,
        ST_WD,
        ST_OUT,
        ST_FIN
    } tset_state_e;

    // Returns 'width' bits of 'blk' starting at bit 'lsb', right-aligned.
    function automatic logic [127:0] take_field(input logic [127:0] blk,
                                                input int          lsb,
                                                input int          width);
        logic [127:0] keep;
        keep = (width >= 128) ? {128{1'b1}} : ((128'd1 << width) - 128'd1);
        return (blk >> lsb) & keep;
    endfunction

endpackage

// File: rtl/tset_entry_derive.sv
// Tset entry derivation: loads kt, encrypts kw to obtain stag, loads stag,
// then encrypts each entry index and splits the ciphertext into
// bucket / label / mask. The AES core lives outside and is driven through
// the aes_* strobe/valid/busy handshake.
module tset_entry_derive
    import tset_pkg::*;
#(
    parameter int B_W   = TSET_B_W,
    parameter int L_W   = TSET_L_W,
    parameter int CNT_W = TSET_CNT_W
) (
    input  logic                     clk,
    input  logic                     RSTn,
    input  logic                     kt_valid,
    output logic                     kt_ready,
    input  logic [127:0]             kt,
    input  logic [127:0]             kw,
    input  logic [CNT_W-1:0]         count,
    output logic [127:0]             aes_key,
    output logic                     aes_krdy,
    input  logic                     aes_kvld,
    output logic [127:0]             aes_din,
    output logic                     aes_drdy,
    input  logic [127:0]             aes_dout,
    input  logic                     aes_dvld,
    input  logic                     aes_bsy,
    output logic                     ent_valid,
    input  logic                     ent_ready,
    output logic [CNT_W-1:0]         ent_index,
    output logic [B_W-1:0]           ent_bucket,
    output logic [L_W-1:0]           ent_label,
    output logic [128-B_W-L_W-1:0]   ent_mask,
    output logic                     ent_last,
    output logic                     done
);

    localparam int M_W = 128 - B_W - L_W;

    tset_state_e        r_state;
    logic [127:0]       r_kt;
    logic [127:0]       r_kw;
    logic [127:0]       r_stag;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_i;

    logic               r_kt_ready;
    logic [127:0]       r_key;
    logic               r_krdy;
    logic [127:0]       r_din;
    logic               r_drdy;
    logic               r_ent_valid;
    logic [CNT_W-1:0]   r_index;
    logic [B_W-1:0]     r_bucket;
    logic [L_W-1:0]     r_label;
    logic [M_W-1:0]     r_mask;
    logic               r_last;
    logic               r_done;

    logic [B_W-1:0]     w_bucket;
    logic [L_W-1:0]     w_label;
    logic [M_W-1:0]     w_mask;
    logic [127:0]       w_index_blk;
    logic               w_is_last;

    // Field split of the ciphertext, index plaintext block and last-entry flag.
    always_comb begin
        w_bucket    = B_W'(take_field(aes_dout, 128 - B_W, B_W));
        w_label     = L_W'(take_field(aes_dout, M_W, L_W));
        w_mask      = M_W'(take_field(aes_dout, 0, M_W));
        w_index_blk = {{(128-CNT_W){1'b0}}, r_i};
        w_is_last   = (r_i == (r_count - CNT_W'(1)));
    end

    // Main sequencer: strobes are one-cycle registered pulses issued only when
    // the core reports idle; kt_valid is only looked at in IDLE.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= ST_IDLE;
            r_kt        <= '0;
            r_kw        <= '0;
            r_stag      <= '0;
            r_count     <= '0;
            r_i         <= '0;
            r_kt_ready  <= 1'b1;
            r_key       <= '0;
            r_krdy      <= 1'b0;
            r_din       <= '0;
            r_drdy      <= 1'b0;
            r_ent_valid <= 1'b0;
            r_index     <= '0;
            r_bucket    <= '0;
            r_label     <= '0;
            r_mask      <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_krdy <= 1'b0;
            r_drdy <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (kt_valid) begin
                        r_kt       <= kt;
                        r_kw       <= kw;
                        r_count    <= count;
                        r_i        <= '0;
                        r_kt_ready <= 1'b0;
                        if (count == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_LDK1;
                        end
                    end
                end
                ST_LDK1: begin
                    if (!aes_bsy) begin
                        r_krdy  <= 1'b1;
                        r_key   <= r_kt;
                        r_state <= ST_WK1;
                    end
                end
                ST_WK1: begin
                    if (aes_kvld) begin
                        r_state <= ST_ENC1;
                    end
                end
                ST_ENC1: begin
                    if (!aes_bsy) begin
                        r_drdy  <= 1'b1;
                        r_din   <= r_kw;
                        r_state <= ST_WD1;
                    end
                end
                ST_WD1: begin
                    if (aes_dvld) begin
                        r_stag  <= aes_dout;
                        r_state <= ST_LDK2;
                    end
                end
                ST_LDK2: begin
                    if (!aes_bsy) begin
                        r_krdy  <= 1'b1;
                        r_key   <= r_stag;
                        r_state <= ST_WK2;
                    end
                end
                ST_WK2: begin
                    if (aes_kvld) begin
                        r_state <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    if (!aes_bsy) begin
                        r_drdy  <= 1'b1;
                        r_din   <= w_index_blk;
                        r_state <= ST_WD;
                    end
                end
                ST_WD: begin
                    if (aes_dvld) begin
                        r_ent_valid <= 1'b1;
                        r_index     <= r_i;
                        r_bucket    <= w_bucket;
                        r_label     <= w_label;
                        r_mask      <= w_mask;
                        r_last      <= w_is_last;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (ent_ready) begin
                        r_ent_valid <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_i     <= r_i + CNT_W'(1);
                            r_state <= ST_ENC;
                        end
                    end
                end
                ST_FIN: begin
                    r_kt_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_kt_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign kt_ready   = r_kt_ready;
    assign aes_key    = r_key;
    assign aes_krdy   = r_krdy;
    assign aes_din    = r_din;
    assign aes_drdy   = r_drdy;
    assign ent_valid  = r_ent_valid;
    assign ent_index  = r_index;
    assign ent_bucket = r_bucket;
    assign ent_label  = r_label;
    assign ent_mask   = r_mask;
    assign ent_last   = r_last;
    assign done       = r_done;

endmodule

// File: tb/tb_tset_entry_derive.sv
// Bench for tset_entry_derive: drives an AES core model (real AES-128) on the
// aes_* handshake, predicts keys, plaintexts and entries from kt/kw/count and
// checks ordering, stall stability, busy respect, done timing and reset.
module tb_tset_entry_derive;
    import tset_pkg::*;

    localparam int CNT_W = 16;
    localparam int LAT   = 3;

    logic                clk;
    logic                RSTn;
    logic                kt_valid;
    logic                kt_ready;
    logic [127:0]        kt;
    logic [127:0]        kw;
    logic [CNT_W-1:0]    count;
    logic [127:0]        aes_key;
    logic                aes_krdy;
    logic                aes_kvld;
    logic [127:0]        aes_din;
    logic                aes_drdy;
    logic [127:0]        aes_dout;
    logic                aes_dvld;
    logic                aes_bsy;
    logic                ent_valid;
    logic                ent_ready;
    logic [CNT_W-1:0]    ent_index;
    logic [7:0]          ent_bucket;
    logic [47:0]         ent_label;
    logic [71:0]         ent_mask;
    logic                ent_last;
    logic                done;

    tset_entry_derive dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .kt_valid   (kt_valid),
        .kt_ready   (kt_ready),
        .kt         (kt),
        .kw         (kw),
        .count      (count),
        .aes_key    (aes_key),
        .aes_krdy   (aes_krdy),
        .aes_kvld   (aes_kvld),
        .aes_din    (aes_din),
        .aes_drdy   (aes_drdy),
        .aes_dout   (aes_dout),
        .aes_dvld   (aes_dvld),
        .aes_bsy    (aes_bsy),
        .ent_valid  (ent_valid),
        .ent_ready  (ent_ready),
        .ent_index  (ent_index),
        .ent_bucket (ent_bucket),
        .ent_label  (ent_label),
        .ent_mask   (ent_mask),
        .ent_last   (ent_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int u = 1; u < 256; u++)
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[v] = s;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w   [44];
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int b = 0; b < 16; b++) st[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) tmp[b] = sbox[st[b]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) st[4*c+rr] = tmp[4*((c+rr)%4)+rr];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
        return res;
    endfunction

    // ---------------- AES core model ----------------
    int           hold_cfg = 0;
    int           lat_cnt;
    int           hold_cnt;
    logic         op_is_data;
    logic [127:0] core_key;
    logic [127:0] core_din;

    always @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            lat_cnt    <= 0;
            hold_cnt   <= 0;
            aes_kvld   <= 1'b0;
            aes_dvld   <= 1'b0;
            aes_dout   <= '0;
            op_is_data <= 1'b0;
            core_key   <= '0;
            core_din   <= '0;
        end else begin
            aes_kvld <= 1'b0;
            aes_dvld <= 1'b0;
            if (aes_krdy) begin
                core_key   <= aes_key;
                lat_cnt    <= LAT;
                op_is_data <= 1'b0;
            end else if (aes_drdy) begin
                core_din   <= aes_din;
                lat_cnt    <= LAT;
                op_is_data <= 1'b1;
            end else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1) begin
                    if (op_is_data) begin
                        aes_dvld <= 1'b1;
                        aes_dout <= aes_enc(core_key, core_din);
                    end else begin
                        aes_kvld <= 1'b1;
                    end
                    hold_cnt <= hold_cfg;
                end
            end else if (hold_cnt != 0) begin
                hold_cnt <= hold_cnt - 1;
            end
        end
    end
    assign aes_bsy = (lat_cnt != 0) || (hold_cnt != 0);

    // ---------------- expectations / monitor ----------------
    typedef struct {
        logic [CNT_W-1:0] idx;
        logic [7:0]       bkt;
        logic [47:0]      lbl;
        logic [71:0]      msk;
        logic             last;
    } ent_t;

    logic [127:0] exp_keys [$];
    logic [127:0] exp_dins [$];
    ent_t         exp_ent  [$];
    logic [127:0] key_log  [$];

    int          n_krdy, n_drdy, n_ent, n_done;
    int          stall_cfg = 0;
    int          stall_cnt;
    bit          gap_en = 1'b0;
    bit          fell;
    int unsigned fall_cyc;
    int unsigned exp_done_cyc;
    logic        prev_bsy, prev_krdy, prev_drdy, prev_valid, prev_done, chk_rdy_next;
    logic [72:0] held_hi;
    logic [71:0] held_mask;
    ent_t        e;

    always @(negedge clk) begin
        if (!RSTn) begin
            prev_bsy     = 1'b0;
            prev_krdy    = 1'b0;
            prev_drdy    = 1'b0;
            prev_valid   = 1'b0;
            prev_done    = 1'b0;
            chk_rdy_next = 1'b0;
            ent_ready    = 1'b0;
        end else begin
            if (aes_krdy) begin
                n_krdy++;
                check("krdy_while_bsy", 128'(aes_bsy), 128'(0));
                check("krdy_single_cycle", 128'(prev_krdy), 128'(0));
                check("krdy_during_out", 128'(ent_valid), 128'(0));
                check("krdy_expected", 128'(exp_keys.size() != 0), 128'(1));
                key_log.push_back(aes_key);
                if (exp_keys.size() != 0) check("aes_key", aes_key, exp_keys.pop_front());
                if (gap_en && fell) check("krdy_first_free_cycle", 128'(cyc - fall_cyc), 128'(1));
                fell = 1'b0;
            end
            if (aes_drdy) begin
                n_drdy++;
                check("drdy_while_bsy", 128'(aes_bsy), 128'(0));
                check("drdy_single_cycle", 128'(prev_drdy), 128'(0));
                check("drdy_during_out", 128'(ent_valid), 128'(0));
                check("drdy_expected", 128'(exp_dins.size() != 0), 128'(1));
                if (exp_dins.size() != 0) check("aes_din", aes_din, exp_dins.pop_front());
                if (gap_en && fell) check("drdy_first_free_cycle", 128'(cyc - fall_cyc), 128'(1));
                fell = 1'b0;
            end
            if (prev_bsy && !aes_bsy) begin
                fell     = 1'b1;
                fall_cyc = cyc;
            end
            prev_bsy  = aes_bsy;
            prev_krdy = aes_krdy;
            prev_drdy = aes_drdy;

            if (ent_valid) begin
                if (!prev_valid) begin
                    check("ent_expected", 128'(exp_ent.size() != 0), 128'(1));
                    if (exp_ent.size() != 0) begin
                        e = exp_ent.pop_front();
                        check("ent_index", 128'(ent_index), 128'(e.idx));
                        check("ent_bucket", 128'(ent_bucket), 128'(e.bkt));
                        check("ent_label", 128'(ent_label), 128'(e.lbl));
                        check("ent_mask", 128'(ent_mask), 128'(e.msk));
                        check("ent_last", 128'(ent_last), 128'(e.last));
                    end
                    held_hi   = {ent_index, ent_bucket, ent_label, ent_last};
                    held_mask = ent_mask;
                    stall_cnt = 0;
                end else begin
                    check("ent_stable_fields", 128'({ent_index, ent_bucket, ent_label, ent_last}), 128'(held_hi));
                    check("ent_stable_mask", 128'(ent_mask), 128'(held_mask));
                end
                ent_ready = (stall_cnt >= stall_cfg);
                stall_cnt++;
                if (ent_ready) begin
                    n_ent++;
                    if (ent_last) exp_done_cyc = cyc + 1;
                end
            end else begin
                ent_ready = (stall_cfg == 0);
            end
            prev_valid = ent_valid;

            if (done) begin
                n_done++;
                check("done_cycle", 128'(cyc), 128'(exp_done_cyc));
                check("done_single_cycle", 128'(prev_done), 128'(0));
                check("kt_ready_during_done", 128'(kt_ready), 128'(0));
                chk_rdy_next = 1'b1;
            end else if (chk_rdy_next) begin
                check("kt_ready_after_done", 128'(kt_ready), 128'(1));
                chk_rdy_next = 1'b0;
            end
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [127:0] kt;
        logic [127:0] kw;
        bit           rnd;
        int           cnt;
        int           stall;
        int           hold;
        bit           gap;
        bit           stag_chk;
        logic [127:0] stag;
        int           n_krdy;
        int           n_drdy;
        int           n_ent;
    } vec_t;

    vec_t tbl [5];
    int   txn_no = 0;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kt_ready"}, 128'(kt_ready), 128'(1));
        check({tag, "_aes_krdy"}, 128'(aes_krdy), 128'(0));
        check({tag, "_aes_drdy"}, 128'(aes_drdy), 128'(0));
        check({tag, "_aes_key"}, aes_key, 128'(0));
        check({tag, "_aes_din"}, aes_din, 128'(0));
        check({tag, "_ent_valid"}, 128'(ent_valid), 128'(0));
        check({tag, "_ent_index"}, 128'(ent_index), 128'(0));
        check({tag, "_ent_bucket"}, 128'(ent_bucket), 128'(0));
        check({tag, "_ent_label"}, 128'(ent_label), 128'(0));
        check({tag, "_ent_mask"}, 128'(ent_mask), 128'(0));
        check({tag, "_ent_last"}, 128'(ent_last), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
    endtask

    // Builds the expected key/plaintext/entry streams and presents one request.
    task automatic launch(input logic [127:0] k, input logic [127:0] w, input int cnt,
                          input int stall, input int hold, input bit gchk);
        logic [127:0] stag;
        logic [127:0] c;
        ent_t         x;
        @(negedge clk);
        stall_cfg = stall;
        hold_cfg  = hold;
        gap_en    = gchk;
        exp_keys.delete();
        exp_dins.delete();
        exp_ent.delete();
        key_log.delete();
        n_krdy = 0; n_drdy = 0; n_ent = 0; n_done = 0;
        fell = 1'b0;
        stag = aes_enc(k, w);
        if (cnt > 0) begin
            exp_keys.push_back(k);
            exp_keys.push_back(stag);
            exp_dins.push_back(w);
            for (int i = 0; i < cnt; i++) begin
                c      = aes_enc(stag, 128'(i));
                x.idx  = CNT_W'(i);
                x.bkt  = c[127:120];
                x.lbl  = c[119:72];
                x.msk  = c[71:0];
                x.last = (i == cnt - 1);
                exp_dins.push_back(128'(i));
                exp_ent.push_back(x);
            end
        end
        check("kt_ready_idle", 128'(kt_ready), 128'(1));
        kt           = k;
        kw           = w;
        count        = CNT_W'(cnt);
        kt_valid     = 1'b1;
        exp_done_cyc = cyc + 1;
        @(negedge clk);
        kt_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        logic [127:0] k;
        logic [127:0] w;
        int           budget;
        k = v.rnd ? rand128() : v.kt;
        w = v.rnd ? rand128() : v.kw;
        repeat (8) @(negedge clk);
        launch(k, w, v.cnt, v.stall, v.hold, v.gap);
        if (v.cnt > 0) begin
            repeat (3) @(negedge clk);
            check("kt_ready_busy", 128'(kt_ready), 128'(0));
            kt       = ~k;
            count    = CNT_W'(7);
            kt_valid = 1'b1;
            @(negedge clk);
            kt_valid = 1'b0;
        end
        budget = 500 + v.cnt * (60 + v.stall + 2 * v.hold);
        for (int t = 0; t < budget && n_done == 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("done_count", 128'(n_done), 128'(1));
        check("krdy_count", 128'(n_krdy), 128'(v.n_krdy));
        check("drdy_count", 128'(n_drdy), 128'(v.n_drdy));
        check("entry_count", 128'(n_ent), 128'(v.n_ent));
        check("keys_left", 128'(exp_keys.size()), 128'(0));
        check("entries_left", 128'(exp_ent.size()), 128'(0));
        if (v.stag_chk) check("stag_second_key", key_log.size() > 1 ? key_log[1] : 128'(0), v.stag);
        $display("TXN %0d count=%0d stall=%0d hold=%0d entries=%0d krdy=%0d drdy=%0d done=%0d",
                 txn_no, v.cnt, v.stall, v.hold, n_ent, n_krdy, n_drdy, n_done);
        txn_no++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   d0;
        bit   found;
        RSTn     = 1'b1;
        kt_valid = 1'b0;
        kt       = '0;
        kw       = '0;
        count    = '0;
        build_sbox();
        #2 RSTn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        RSTn = 1'b1;

        //            kt                                     kw                                     rnd cnt st  hd gap schk stag                                    kr dr en
        tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 1'b0, 1, 0,  0, 1'b0, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2, 2, 1};
        tbl[1] = '{128'h0, 128'h0, 1'b1, 4, 0,  0, 1'b0, 1'b0, 128'h0, 2, 5, 4};
        tbl[2] = '{128'h0, 128'h0, 1'b1, 3, 10, 0, 1'b0, 1'b0, 128'h0, 2, 4, 3};
        tbl[3] = '{128'h0, 128'h0, 1'b1, 2, 0,  5, 1'b1, 1'b0, 128'h0, 2, 3, 2};
        tbl[4] = '{128'h0, 128'h0, 1'b1, 0, 0,  0, 1'b0, 1'b0, 128'h0, 0, 0, 0};
        for (int r = 0; r < 5; r++) run_txn(tbl[r]);

        // Reset while waiting for the ciphertext of entry 2 of 5.
        repeat (8) @(negedge clk);
        launch(rand128(), rand128(), 5, 0, 0, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            @(negedge clk);
            if (aes_drdy && aes_din == 128'd2) found = 1'b1;
        end
        check("reached_entry2", 128'(found), 128'(1));
        @(negedge clk);
        RSTn = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        d0 = n_done;
        repeat (3) @(negedge clk);
        RSTn = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_reset", 128'(n_done), 128'(d0));
        check("idle_after_reset", 128'(kt_ready), 128'(1));
        $display("TXN %0d aborted by reset during entry 2 of 5, done=%0d", txn_no, n_done);
        txn_no++;
        run_txn(tbl[1]);

        // Randomised requests.
        for (int r = 0; r < 6; r++) begin
            v.kt       = '0;
            v.kw       = '0;
            v.rnd      = 1'b1;
            v.cnt      = int'($urandom_range(0, 5));
            v.stall    = int'($urandom_range(0, 3));
            v.hold     = int'($urandom_range(0, 4));
            v.gap      = (v.stall == 0) && (v.hold >= 2);
            v.stag_chk = 1'b0;
            v.stag     = '0;
            v.n_krdy   = (v.cnt > 0) ? 2 : 0;
            v.n_drdy   = (v.cnt > 0) ? v.cnt + 1 : 0;
            v.n_ent    = v.cnt;
            run_txn(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
